signal_capture: RTL and testbench

//   Sink-side counterpart of the sample playback feeder: records a stream of

---
 rtl/signal_capture.sv | 132 +++++++++++++
 tb/tb_signal_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_capture.sv
// Frame snapshot buffer: arm captures 2**ADDR_W samples into an internal RAM that is read back through a registered random-access port.
// Define CAPTURE_TRIG_EN to hold off the capture until a sample reaches THRESH.
module signal_capture #(
  parameter int unsigned       DATA_W = 12,
  parameter int unsigned       ADDR_W = 10,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'(12'h800)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_signal,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef CAPTURE_TRIG_EN
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_e;
  localparam state_e ARM_STATE = S_WAIT_TRIG;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;
  localparam state_e ARM_STATE = S_CAPTURE;

  // Threshold only matters when the trigger is built in.
  if (THRESH == '0) begin : g_thresh_unused
  end
`endif

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [CNT_W-1:0]  wr_count_d;

  assign wr_addr_c  = wr_count[ADDR_W-1:0];
  assign wr_count_d = wr_count + CNT_W'(1);

  // Write strobe; reset or abort in the same cycle discards the sample.
  always_comb begin
    wr_en_c = 1'b0;
    if (!rst && !abort) begin
      case (state_q)
        S_CAPTURE:   wr_en_c = in_valid;
`ifdef CAPTURE_TRIG_EN
        S_WAIT_TRIG: wr_en_c = in_valid && (in_signal >= THRESH);
`endif
        default:     wr_en_c = 1'b0;
      endcase
    end
  end

  // Capture control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_count <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_q  <= ARM_STATE;
            wr_count <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
`ifdef CAPTURE_TRIG_EN
        S_WAIT_TRIG: begin
          if (wr_en_c) begin
            state_q  <= S_CAPTURE;
            wr_count <= CNT_W'(1);
          end
        end
`endif
        S_CAPTURE: begin
          if (wr_en_c) begin
            wr_count <= wr_count_d;
            if (wr_count_d == CNT_W'(DEPTH)) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_c] <= in_signal;
    end
  end

  // Registered read port; a read of the address being written returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_signal_capture.sv
// Directed bench for signal_capture: reset, full frame, gaps/overflow, abort/re-arm, mid-capture reset, trigger.
module tb_signal_capture;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_signal;
  logic        arm;
  logic        abort;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic [10:0] wr_count;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signal_capture #(
    .DATA_W (12),
    .ADDR_W (ADDR_W),
    .THRESH (12'h800)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_signal (in_signal),
    .arm       (arm),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_count  (wr_count),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    in_valid  = 1'b1;
    in_signal = v;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [11:0] d);
    in_valid = 1'b0;
    rd_addr  = ADDR_W'(a);
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; arm = 1'b1; abort = 1'b0;
    in_signal = 12'h123; rd_addr = '0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wr_count !== 11'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", wr_count); end
    n_cmp++; if (rd_data !== 12'h000) begin n_err++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    rst = 1'b0; arm = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_frame();
    logic [11:0] d;
    pulse_arm();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ff_armed_busy: got %b want 1", busy); end
    n_cmp++; if (wr_count !== 11'd0) begin n_err++; $display("FAIL ff_armed_count: got %0d want 0", wr_count); end
    for (int k = 0; k < 1023; k++) send(12'(k));
    n_cmp++; if (wr_count !== 11'd1023) begin n_err++; $display("FAIL ff_count_1023: got %0d want 1023", wr_count); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ff_early_done: got %b want 0", done); end
    send(12'd1023);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ff_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ff_busy_end: got %b want 0", busy); end
    n_cmp++; if (wr_count !== 11'd1024) begin n_err++; $display("FAIL ff_count: got %0d want 1024", wr_count); end
    for (int k = 0; k < int'(DEPTH); k++) begin
      read_word(k, d);
      n_cmp++;
      if (d !== 12'(k)) begin n_err++; $display("FAIL ff_read[%0d]: got %h want %h", k, d, 12'(k)); end
    end
  endtask

  task automatic test_gaps_overflow();
    logic [11:0] d;
    pulse_arm();
    for (int k = 0; k < int'(DEPTH); k++) begin
      send(12'(k + 100));
      in_signal = 12'hBAD;
      tick();
      if (k == 9) begin
        n_cmp++; if (wr_count !== 11'd10) begin n_err++; $display("FAIL gap_count_10: got %0d want 10", wr_count); end
      end
    end
    for (int k = 0; k < 50; k++) send(12'hFFF);
    n_cmp++; if (wr_count !== 11'd1024) begin n_err++; $display("FAIL gap_count: got %0d want 1024", wr_count); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL gap_done: got %b want 1", done); end
    read_word(0, d);
    n_cmp++; if (d !== 12'd100) begin n_err++; $display("FAIL gap_mem0: got %h want %h", d, 12'd100); end
    read_word(1, d);
    n_cmp++; if (d !== 12'd101) begin n_err++; $display("FAIL gap_mem1: got %h want %h", d, 12'd101); end
    read_word(1023, d);
    n_cmp++; if (d !== 12'd1123) begin n_err++; $display("FAIL gap_mem1023: got %h want %h", d, 12'd1123); end
  endtask

  task automatic test_abort_rearm();
    logic [11:0] d;
    pulse_arm();
    for (int k = 0; k < 300; k++) begin
      if (k == 150) arm = 1'b1;
      send(12'(k + 7));
      arm = 1'b0;
      if (k == 150) begin
        n_cmp++; if (wr_count !== 11'd151) begin n_err++; $display("FAIL ab_arm_ignored: got %0d want 151", wr_count); end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ab_done: got %b want 0", done); end
    n_cmp++; if (wr_count !== 11'd300) begin n_err++; $display("FAIL ab_count: got %0d want 300", wr_count); end
    read_word(299, d);
    n_cmp++; if (d !== 12'd306) begin n_err++; $display("FAIL ab_mem299: got %h want %h", d, 12'd306); end
    pulse_arm();
    n_cmp++; if (wr_count !== 11'd0) begin n_err++; $display("FAIL rearm_count: got %0d want 0", wr_count); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rearm_busy: got %b want 1", busy); end
    rd_addr = 10'd0;
    send(12'hABC);
    n_cmp++; if (rd_data !== 12'd7) begin n_err++; $display("FAIL rbw_old_word: got %h want %h", rd_data, 12'd7); end
    n_cmp++; if (wr_count !== 11'd1) begin n_err++; $display("FAIL rearm_count1: got %0d want 1", wr_count); end
    for (int k = 1; k < 5; k++) send(12'(12'hABC + k));
    read_word(0, d);
    n_cmp++; if (d !== 12'hABC) begin n_err++; $display("FAIL rearm_mem0: got %h want ABC", d); end
    read_word(4, d);
    n_cmp++; if (d !== 12'hAC0) begin n_err++; $display("FAIL rearm_mem4: got %h want AC0", d); end
    read_word(5, d);
    n_cmp++; if (d !== 12'd12) begin n_err++; $display("FAIL rearm_mem5_old: got %h want %h", d, 12'd12); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (wr_count !== 11'd5) begin n_err++; $display("FAIL ab2_count: got %0d want 5", wr_count); end
  endtask

  task automatic test_rst_mid();
    logic [11:0] d;
    pulse_arm();
    for (int k = 0; k < 500; k++) send(12'(k + 12'h200));
    n_cmp++; if (wr_count !== 11'd500) begin n_err++; $display("FAIL rst_pre_count: got %0d want 500", wr_count); end
    in_valid = 1'b1; in_signal = 12'hEEE; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (wr_count !== 11'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", wr_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    for (int k = 0; k < 10; k++) send(12'hDDD);
    n_cmp++; if (wr_count !== 11'd0) begin n_err++; $display("FAIL rst_noarm_count: got %0d want 0", wr_count); end
    read_word(0, d);
    n_cmp++; if (d !== 12'h200) begin n_err++; $display("FAIL rst_mem0: got %h want 200", d); end
    read_word(499, d);
    n_cmp++; if (d !== 12'h3F3) begin n_err++; $display("FAIL rst_mem499: got %h want 3F3", d); end
    read_word(500, d);
    n_cmp++; if (d !== 12'd600) begin n_err++; $display("FAIL rst_inflight: got %h want %h", d, 12'd600); end
  endtask

  task automatic test_trigger();
    logic [11:0] d;
    logic [11:0] exp0, exp1, exp20, exp1023;
    logic [10:0] exp_cnt;
`ifdef CAPTURE_TRIG_EN
    exp0 = 12'h900; exp1 = 12'd0;   exp20 = 12'd19;  exp1023 = 12'd1022; exp_cnt = 11'd0;
`else
    exp0 = 12'h100; exp1 = 12'h100; exp20 = 12'h900; exp1023 = 12'd1002; exp_cnt = 11'd20;
`endif
    pulse_arm();
    for (int k = 0; k < 20; k++) send(12'h100);
    n_cmp++; if (wr_count !== exp_cnt) begin n_err++; $display("FAIL trig_pre_count: got %0d want %0d", wr_count, exp_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL trig_busy: got %b want 1", busy); end
    send(12'h900);
    for (int k = 0; k < 1023; k++) send(12'(k));
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL trig_done: got %b want 1", done); end
    n_cmp++; if (wr_count !== 11'd1024) begin n_err++; $display("FAIL trig_count: got %0d want 1024", wr_count); end
    read_word(0, d);
    n_cmp++; if (d !== exp0) begin n_err++; $display("FAIL trig_mem0: got %h want %h", d, exp0); end
    read_word(1, d);
    n_cmp++; if (d !== exp1) begin n_err++; $display("FAIL trig_mem1: got %h want %h", d, exp1); end
    read_word(20, d);
    n_cmp++; if (d !== exp20) begin n_err++; $display("FAIL trig_mem20: got %h want %h", d, exp20); end
    read_word(1023, d);
    n_cmp++; if (d !== exp1023) begin n_err++; $display("FAIL trig_mem1023: got %h want %h", d, exp1023); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps_overflow();
    test_abort_rearm();
    test_rst_mid();
    test_trigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
